// File: rtl/jk_test_pkg.sv
// Shared constants for the JK flip-flop stimulus/checker: JK encodings,
// checker FSM state codes and the fixed 8-entry stimulus pattern.
package jk_test_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Entry 0 is a reset so the reference Q is defined from the first step.
  function automatic logic [1:0] pat_lookup(input logic [2:0] idx);
    case (idx)
      3'd0:    return JK_RST;
      3'd1:    return JK_SET;
      3'd2:    return JK_TGL;
      3'd3:    return JK_TGL;
      3'd4:    return JK_HOLD;
      3'd5:    return JK_SET;
      3'd6:    return JK_HOLD;
      default: return JK_TGL;
    endcase
  endfunction

  function automatic logic jk_ref_next(input logic [1:0] jk, input logic q);
    case (jk)
      JK_RST:  return 1'b0;
      JK_SET:  return 1'b1;
      JK_TGL:  return ~q;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_stim_checker_ff_phase_gen.sv
// Phase counter that divides the system clock into the flip-flop clock and
// emits one-cycle strobes for the falling edge and the end-of-step sample.
module ff_phase_gen #(
  parameter int DIV = 4
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic run_i,
  output logic ff_clk_o,
  output logic fall_o,
  output logic sample_o,
  output logic step_end_o
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(DIV / 2);
  localparam logic [PW-1:0] P_PRE_FALL = PW'(DIV / 2 - 1);

  logic          active_q;
  logic [PW-1:0] p_q, p_d;
  logic          ff_clk_q, ff_clk_d;

  // run_i is the next-cycle run state: a fresh run always enters at p=0.
  always_comb begin
    p_d = '0;
    if (run_i && active_q) begin
      p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
    end
    ff_clk_d = run_i && (p_d < P_HALF);
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      active_q <= 1'b0;
      p_q      <= '0;
      ff_clk_q <= 1'b0;
    end else begin
      active_q <= run_i;
      p_q      <= p_d;
      ff_clk_q <= ff_clk_d;
    end
  end

  assign ff_clk_o   = ff_clk_q;
  assign fall_o     = active_q && (p_q == P_PRE_FALL);
  assign sample_o   = active_q && (p_q == P_LAST);
  assign step_end_o = sample_o;

endmodule

// File: rtl/jk_stim_checker.sv
// Drives a negedge JK flip-flop from a fixed pattern, tracks the expected Q
// with a reference model and counts saturating mismatches per test pass.
module jk_stim_checker
  import jk_test_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int STEP_W = 3,
  parameter int ERR_W  = 8
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Q_dut,
  output logic              Ff_Clk,
  output logic              J,
  output logic              K,
  output logic              Busy,
  output logic              Done,
  output logic [ERR_W-1:0]  Err_Count,
  output logic [STEP_W-1:0] Step,
  output logic [1:0]        dbg_state_o
);

  // Handshake: Start is sampled only in IDLE/DONE; Busy is high for exactly
  // the pass, and Done stays high (with results held) until the next Start.

  logic [1:0]        state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d, step_inc;
  logic [1:0]        jk_q, jk_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              exp_q, exp_d;
  logic [2:0]        pat_idx_next;
  logic              run_next;
  logic              fall_stb, sample_stb, step_end_stb;

  assign step_inc     = step_q + STEP_W'(1);
  assign pat_idx_next = 3'(step_inc);
  assign run_next     = (state_d == ST_RUN);

  ff_phase_gen #(.DIV(DIV)) u_phase (
    .Clk        (Clk),
    .Resetn     (Resetn),
    .run_i      (run_next),
    .ff_clk_o   (Ff_Clk),
    .fall_o     (fall_stb),
    .sample_o   (sample_stb),
    .step_end_o (step_end_stb)
  );

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    jk_d    = jk_q;
    err_d   = err_q;
    exp_d   = exp_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_RUN;
          step_d  = '0;
          err_d   = '0;
          jk_d    = pat_lookup(3'd0);
        end
      end
      ST_RUN: begin
        // Reference advances on the same edge the DUT clock falls.
        if (fall_stb) begin
          exp_d = jk_ref_next(jk_q, exp_q);
        end
        if (sample_stb && (Q_dut != exp_q) && (err_q != {ERR_W{1'b1}})) begin
          err_d = err_q + ERR_W'(1);
        end
        if (step_end_stb) begin
          if (step_q == {STEP_W{1'b1}}) begin
            state_d = ST_DONE;
          end else begin
            step_d = step_inc;
            jk_d   = pat_lookup(pat_idx_next);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      jk_q    <= JK_HOLD;
      err_q   <= '0;
      exp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      jk_q    <= jk_d;
      err_q   <= err_d;
      exp_q   <= exp_d;
    end
  end

  assign J           = jk_q[1];
  assign K           = jk_q[0];
  assign Busy        = (state_q == ST_RUN);
  assign Done        = (state_q == ST_DONE);
  assign Err_Count   = err_q;
  assign Step        = step_q;
  assign dbg_state_o = state_q;

endmodule
